// File: rtl/sync_fifo_stream_drain_pkg.sv
// Shared types and defaults for the FIFO drain stage: default widths, packet
// length and the skid-buffer occupancy encoding.
package sync_fifo_stream_drain_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int PKT_LEN_DEF    = 4;
  localparam int CNT_BIT_DEF    = 3;

  typedef logic [FIFO_WIDTH_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/sync_fifo_stream_drain_if.sv
// Valid/ready stream carrying one data word plus a packet-end marker.
interface sync_fifo_stream_drain_if #(
  parameter int FIFO_WIDTH = 16
);

  logic                  valid;
  logic                  ready;
  logic [FIFO_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, output data, output last, input  ready);
  modport slave  (input  valid, input  data, input  last, output ready);

endinterface

// File: rtl/sync_fifo_stream_drain_skid_buf.sv
// Two-entry skid buffer: entry 0 is the presented word, entry 1 catches a pop
// that lands while the consumer stalls.
module sync_fifo_stream_drain_skid_buf
  import sync_fifo_stream_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [FIFO_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output occ_t                  o_count,
  output logic                  o_valid,
  output logic [FIFO_WIDTH-1:0] o_data
);

  occ_t                  r_count;
  logic [FIFO_WIDTH-1:0] r_ent0_p0;
  logic [FIFO_WIDTH-1:0] r_ent1_p0;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop & (r_count != OCC_EMPTY);
  assign w_push = i_push & ((r_count != OCC_FULL) | w_pop);

  // Stage p0: occupancy and both entries; entry 1 shifts down whenever entry 0 leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= OCC_EMPTY;
      r_ent0_p0 <= '0;
      r_ent1_p0 <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == OCC_EMPTY) r_ent0_p0 <= i_push_data;
          else                      r_ent1_p0 <= i_push_data;
          r_count <= (r_count == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        end
        2'b01: begin
          if (r_count == OCC_FULL) r_ent0_p0 <= r_ent1_p0;
          r_count <= (r_count == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        end
        2'b11: begin
          if (r_count == OCC_FULL) begin
            r_ent0_p0 <= r_ent1_p0;
            r_ent1_p0 <= i_push_data;
          end else begin
            r_ent0_p0 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != OCC_EMPTY);
  assign o_data  = r_ent0_p0;

endmodule

// File: rtl/sync_fifo_stream_drain.sv
// FIFO read-side drain: pops into a skid buffer and re-issues words as a framed
// valid/ready stream with out_last every PKT_LEN beats and a packet counter.
module sync_fifo_stream_drain
  import sync_fifo_stream_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int PKT_LEN    = PKT_LEN_DEF,
  parameter int CNT_BIT    = CNT_BIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_fifo_empty,
  input  logic [FIFO_WIDTH-1:0]    i_fifo_do,
  output logic                     o_fifo_rd,
  output logic [15:0]              o_pkt_cnt,
  sync_fifo_stream_drain_if.master o_strm
);

  localparam logic [CNT_BIT-1:0] LAST_BEAT = CNT_BIT'(PKT_LEN - 1);

  occ_t                  w_count;
  logic                  w_valid;
  logic [FIFO_WIDTH-1:0] w_data;
  logic                  w_beat;
  logic                  w_last;
  logic [CNT_BIT-1:0]    r_beat_cnt;
  logic [15:0]           r_pkt_cnt;

  // Pop gating looks only at registered occupancy, so out_ready never reaches fifo_rd
  assign o_fifo_rd = i_en & ~i_fifo_empty & (w_count != OCC_FULL);
  assign w_beat    = w_valid & o_strm.ready;
  assign w_last    = w_valid & (r_beat_cnt == LAST_BEAT);

  sync_fifo_stream_drain_skid_buf #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (o_fifo_rd),
    .i_push_data (i_fifo_do),
    .i_pop       (w_beat),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_data      (w_data)
  );

  // Framing state survives en gaps and FIFO underflow; it only moves on a beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_beat_cnt <= '0;
        r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign o_strm.valid = w_valid;
  assign o_strm.data  = w_data;
  assign o_strm.last  = w_last;
  assign o_pkt_cnt    = r_pkt_cnt;

endmodule
